spi_arbiter: RTL and testbench
==============================

Name: spi_arbiter

Overview:
- Shares one spi_master between NUM_REQ independent requesters using round-robin arbitration.
- Each grant runs exactly one SPI word transaction with its own CS framing. The requester's 16-bit control word is applied for the whole transaction.
- Returns the received word to the granted requester, with a timeout/error indication.
- Sits between the register/DMA clients and the spi_master control interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 4096, sys_clk cycles allowed from issue to m_rx_valid before an error response.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid; held until accepted
- req_ready  out  NUM_REQ  per-requester accept
- req_data  in  32*NUM_REQ  flattened tx words; requester i owns bits [32i+31:32i]
- req_ctrl  in  16*NUM_REQ  flattened control words; same control format as spi_master
- resp_valid  out  NUM_REQ  one-cycle response pulse to the owning requester
- resp_data  out  32  shared response word
- resp_err  out  1  qualifies resp_valid; 1 = timeout
- m_control  out  16  to spi_master control
- m_tx_valid  out  1  to spi_master tx_data_valid
- m_tx_ready  in  1  from spi_master tx_data_ready
- m_tx_data  out  32  to spi_master tx_data
- m_rx_data  in  32  from spi_master rx_data
- m_rx_valid  in  1  from spi_master rx_data_valid
- busy  out  1  state != IDLE
- grant_id  out  3  index of the current or last granted requester

Behaviour:
- Reset values:
  - req_ready=0, resp_valid=0, resp_data=0, resp_err=0.
  - m_control=0, m_tx_valid=0, m_tx_data=0, busy=0, grant_id=0.
  - rr_ptr=NUM_REQ-1, so requester 0 wins first. State=IDLE.
- Reset mid-transaction: aborts immediately to the reset state. No response is issued.
- FSM states: IDLE, ISSUE, WAIT_RX, WAIT_IDLE.
- IDLE:
  - Winner = first i with req_valid[i], searching from rr_ptr+1 upward modulo NUM_REQ.
  - req_ready[winner] is combinational and is the only ready asserted. Ready is never asserted outside IDLE.
  - On the handshake:
    - Capture data into m_tx_data and the sanitised ctrl into m_control.
    - grant_id<=winner, rr_ptr<=winner.
    - Go to ISSUE next cycle with m_tx_valid=1.
- Sanitisation: m_control = {ctrl[15:8], 3'd1, ctrl[4:0]}. This forces burst_len=1, so the slave releases cs_n after each word.
- m_control and m_tx_data hold stable from capture until the next capture, including through IDLE.
- ISSUE:
  - m_tx_valid stays 1 until the cycle m_tx_valid && m_tx_ready. It drops the cycle after.
  - Then go to WAIT_RX; the timeout counter loads 0.
- WAIT_RX:
  - The counter increments every cycle.
  - If m_rx_valid: resp_data<=m_rx_data, resp_err<=0, resp_valid[grant_id] pulses 1 cycle, go to WAIT_IDLE.
  - Else if counter == TIMEOUT_CYC-1: resp_data<=0, resp_err<=1, pulse resp_valid[grant_id], go to WAIT_IDLE.
  - m_rx_valid and timeout in the same cycle: m_rx_valid wins (no error).
- WAIT_IDLE:
  - Wait for m_tx_ready==1, i.e. CS released and the slave idle. Then go to IDLE.
  - m_rx_valid here (late after timeout) is ignored.
  - There is no timeout in this state.
  - Minimum gap between grants is 1 IDLE cycle.
- resp_data and resp_err hold their last value between pulses. resp_valid is registered.
- Fairness: a requester holding valid is granted within NUM_REQ grants.
- req_valid dropping before ready is tolerated; it is ignored.
- Back-to-back requests from the same sole requester are each granted.
- NUM_REQ<8: grant_id upper bits are 0.

Test Plan:
- Single request: req 1 data=32'hA5, ctrl=16'h3802 with a loopback slave.
  - req_ready[1] pulses once; m_control=16'h3822.
  - resp_valid[1] pulses once with resp_data=32'hA5, resp_err=0.
- All 4 requesters assert valid together, each held until its ready.
  - Grant order 0,1,2,3, then 0 again if re-asserted.
  - Each resp_valid goes only to its owner.
- Requesters 0 and 2 valid continuously: grants alternate 0,2,0,2. req_ready is never asserted outside IDLE.
- Slave stub that never raises m_rx_valid, TIMEOUT_CYC=16:
  - resp_err=1, resp_data=0 exactly 16 cycles after the issue handshake.
  - A late m_rx_valid is ignored.
- m_rx_valid on the timeout cycle itself: resp_err=0 and resp_data=m_rx_data.
- Assert sys_rst_n=0 during WAIT_RX:
  - All outputs return to reset values with no resp_valid.
  - The next request is granted to requester 0 first.

Source files
------------

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter that shares one spi_master between
// NUM_REQ requesters. Each grant runs one word transaction with its own CS
// framing and returns the received word (or a timeout error) to its owner.
module spi_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_data,
  input  logic [16*NUM_REQ-1:0]  req_ctrl,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_data,
  output logic                   resp_err,
  output logic [15:0]            m_control,
  output logic                   m_tx_valid,
  input  logic                   m_tx_ready,
  output logic [31:0]            m_tx_data,
  input  logic [31:0]            m_rx_data,
  input  logic                   m_rx_valid,
  output logic                   busy,
  output logic [2:0]             grant_id
);

  localparam int unsigned NREQ  = NUM_REQ;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_RX   = 2'd2;
  localparam logic [1:0] S_WAIT_IDLE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [2:0]         rr_q, rr_d;
  logic [2:0]         grant_q, grant_d;
  logic [15:0]        ctrl_q, ctrl_d;
  logic [31:0]        txd_q, txd_d;
  logic               txv_q, txv_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rv_q, rv_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rerr_q, rerr_d;

  logic               found;
  logic [2:0]         win;
  logic [31:0]        win_data;
  logic [15:0]        win_ctrl;
  logic [NUM_REQ-1:0] grant_oh;
  int unsigned        idx;
  logic               unused_ctrl_bits;

  // Round-robin winner search starting just above the last grant.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    win_ctrl = '0;
    idx      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(rr_q) + k) % NREQ;
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found && idx == j && req_valid[j]) begin
          found    = 1'b1;
          win      = 3'(j);
          win_data = req_data[32*j +: 32];
          win_ctrl = req_ctrl[16*j +: 16];
        end
      end
    end
  end

  // burst_len bits of the requester control are replaced below.
  assign unused_ctrl_bits = ^win_ctrl[7:5];

  // One-hot decode of the winner (ready) and of the owner (response pulse).
  always_comb begin
    req_ready = '0;
    grant_oh  = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      req_ready[j] = (state_q == S_IDLE) && found && (win == 3'(j));
      grant_oh[j]  = (grant_q == 3'(j));
    end
  end

  // Transaction sequencing: grant, issue, wait for rx or timeout, wait for CS release.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    ctrl_d  = ctrl_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    cnt_d   = cnt_q;
    rv_d    = '0;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          ctrl_d  = {win_ctrl[15:8], 3'd1, win_ctrl[4:0]};
          txd_d   = win_data;
          grant_d = win;
          rr_d    = win;
          txv_d   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (txv_q && m_tx_ready) begin
          txv_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT_RX;
        end
      end
      S_WAIT_RX: begin
        cnt_d = cnt_q + 1'b1;
        if (m_rx_valid) begin
          rdata_d = m_rx_data;
          rerr_d  = 1'b0;
          rv_d    = grant_oh;
          state_d = S_WAIT_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          rerr_d  = 1'b1;
          rv_d    = grant_oh;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (m_tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= 3'(NUM_REQ - 1);
      grant_q <= '0;
      ctrl_q  <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      cnt_q   <= '0;
      rv_q    <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      ctrl_q  <= ctrl_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  assign resp_valid = rv_q;
  assign resp_data  = rdata_q;
  assign resp_err   = rerr_q;
  assign m_control  = ctrl_q;
  assign m_tx_data  = txd_q;
  assign m_tx_valid = txv_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: randomized requesters and a behavioural SPI slave, checked
// every cycle against a transaction-level model of the arbitration rules.
module tb_spi_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            sys_rst_n;
  logic [N-1:0]    req_valid, req_ready, resp_valid;
  logic [32*N-1:0] req_data;
  logic [16*N-1:0] req_ctrl;
  logic [31:0]     resp_data, m_tx_data, m_rx_data;
  logic            resp_err, m_tx_valid, m_tx_ready, m_rx_valid, busy;
  logic [15:0]     m_control;
  logic [2:0]      grant_id;

  always #5 clk = ~clk;

  spi_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_ctrl(req_ctrl),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .m_control(m_control), .m_tx_valid(m_tx_valid), .m_tx_ready(m_tx_ready),
    .m_tx_data(m_tx_data), .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid),
    .busy(busy), .grant_id(grant_id)
  );

  int n_pass = 0, n_fail = 0, n_total = 0;
  int cyc = 0;

  // requester model
  bit          pend[N];
  bit          cont[N];
  logic [31:0] rdata[N];
  logic [15:0] rctrl[N];
  int          last_grant;
  int          grant_log[$];
  int          drop_pct = 0;

  // transaction model
  bit          outst, resp_seen, txv_exp, hs_done, use_xor;
  int          owner, hs_cyc, lat, rel, exp_resp_cyc, lat_mode;
  logic [31:0] e_txd, e_rsp_data, rx_word, nx_rsp_data;
  logic [15:0] e_ctrl;
  logic        e_err, nx_err;
  int          e_gid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [15:0] sanitise(input logic [15:0] c);
    return {c[15:8], 3'd1, c[4:0]};
  endfunction

  function automatic bit any_pend();
    bit a = 0;
    for (int i = 0; i < N; i++) a |= pend[i];
    return a;
  endfunction

  task automatic arm(input int i);
    pend[i]  = 1;
    rdata[i] = $urandom;
    rctrl[i] = 16'($urandom);
  endtask

  function automatic int pick_lat();
    int r = $urandom_range(0, 9);
    if (lat_mode >= 0) return lat_mode;
    if (r == 0) return 0;
    if (r == 1) return TO;
    if (r == 2) return $urandom_range(TO + 1, TO + 8);
    return $urandom_range(1, TO - 1);
  endfunction

  // One clock: drive inputs at negedge, sample #1 later, compare, update model.
  task automatic cycle();
    int          w;
    logic [N-1:0] exp_rdy, oh;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pend[i];
      req_data[32*i +: 32]  = rdata[i];
      req_ctrl[16*i +: 16]  = rctrl[i];
    end
    m_rx_valid = 1'b0;
    m_rx_data  = $urandom;
    if (outst && hs_done) begin
      m_tx_ready = (cyc >= hs_cyc + rel);
      if (lat > 0 && cyc == hs_cyc + lat) begin
        m_rx_valid = 1'b1;
        m_rx_data  = rx_word;
      end
    end else begin
      m_tx_ready = ($urandom_range(0, 3) != 0);
    end
    #1;
    w = -1;
    if (!outst)
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (last_grant + k) % N;
        if (w < 0 && pend[i]) w = i;
      end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(outst));
    chk("m_tx_valid", 32'(m_tx_valid), 32'(txv_exp));
    chk("m_control", 32'(m_control), 32'(e_ctrl));
    chk("m_tx_data", m_tx_data, e_txd);
    chk("grant_id", 32'(grant_id), 32'(e_gid));
    if (outst && hs_done && !resp_seen && cyc == exp_resp_cyc) begin
      oh = '0;
      oh[owner] = 1'b1;
      e_rsp_data = nx_rsp_data;
      e_err      = nx_err;
      resp_seen  = 1;
      chk("resp_valid_owner", 32'(resp_valid), 32'(oh));
    end else begin
      chk("resp_valid_idle", 32'(resp_valid), 32'd0);
    end
    chk("resp_data", resp_data, e_rsp_data);
    chk("resp_err", 32'(resp_err), 32'(e_err));
    // model update
    if (txv_exp && m_tx_ready) begin
      txv_exp = 0;
      hs_done = 1;
      hs_cyc  = cyc;
      if (lat >= 1 && lat <= TO) begin
        exp_resp_cyc = cyc + lat + 1;
        nx_rsp_data  = rx_word;
        nx_err       = 1'b0;
      end else begin
        exp_resp_cyc = cyc + TO + 1;
        nx_rsp_data  = '0;
        nx_err       = 1'b1;
      end
    end
    if (outst && resp_seen && m_tx_ready) outst = 0;
    if (w >= 0) begin
      outst = 1; resp_seen = 0; hs_done = 0; txv_exp = 1;
      owner = w; last_grant = w; e_gid = w;
      e_txd  = rdata[w];
      e_ctrl = sanitise(rctrl[w]);
      grant_log.push_back(w);
      lat     = pick_lat();
      rel     = (lat > 0) ? lat + $urandom_range(1, 3) : $urandom_range(1, 25);
      rx_word = rdata[w] ^ (use_xor ? $urandom : 32'd0);
      pend[w] = 0;
      if (cont[w]) arm(w);
    end
    for (int i = 0; i < N; i++)
      if (pend[i] && drop_pct > 0 && $urandom_range(0, 99) < drop_pct) pend[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc++;
    sys_rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; cont[i] = 0; end
    req_valid = '0; m_rx_valid = 1'b0; m_tx_ready = 1'b1;
    last_grant = N - 1; outst = 0; txv_exp = 0; hs_done = 0; resp_seen = 0;
    e_ctrl = '0; e_txd = '0; e_gid = 0; e_rsp_data = '0; e_err = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_m_control", 32'(m_control), 32'd0);
    chk("rst_m_tx_valid", 32'(m_tx_valid), 32'd0);
    chk("rst_m_tx_data", m_tx_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    @(negedge clk);
    cyc++;
    sys_rst_n = 1'b1;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((any_pend() || outst) && n < budget) begin cycle(); n++; end
    if (n >= budget) begin
      n_total++; n_fail++;
      $error("FAIL idle_budget cyc=%0d observed=busy expected=idle", cyc);
    end
  endtask

  task automatic run_grants(input int cnt, input bit do_arm, input int budget);
    int target = grant_log.size() + cnt;
    int n = 0;
    while (grant_log.size() < target && n < budget) begin
      if (do_arm)
        for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 7) == 0) arm(i);
      cycle();
      n++;
    end
    if (n >= budget) begin
      n_total++; n_fail++;
      $error("FAIL grant_budget cyc=%0d observed=%0d expected=%0d", cyc, grant_log.size(), target);
    end
  endtask

  initial begin
    int base;
    int exp_alt[6] = '{2, 0, 2, 0, 2, 0};
    sys_rst_n = 1'b0; req_valid = '0; req_data = '0; req_ctrl = '0;
    m_tx_ready = 1'b1; m_rx_valid = 1'b0; m_rx_data = '0;
    use_xor = 0; lat_mode = 5;
    for (int i = 0; i < N; i++) begin pend[i] = 0; cont[i] = 0; rdata[i] = '0; rctrl[i] = '0; end
    do_reset();

    // single request through a loopback slave
    base = grant_log.size();
    pend[1] = 1; rdata[1] = 32'hA5; rctrl[1] = 16'h3802;
    run_idle(200);
    chk("single_grants", 32'(grant_log.size() - base), 32'd1);
    chk("single_winner", 32'(grant_log[base]), 32'd1);
    chk("single_ctrl", 32'(m_control), 32'h3822);
    chk("single_rdata", resp_data, 32'hA5);
    chk("single_err", 32'(resp_err), 32'd0);

    // all four together, then requester 0 again
    do_reset();
    use_xor = 1; lat_mode = -1;
    base = grant_log.size();
    for (int i = 0; i < N; i++) arm(i);
    run_idle(500);
    arm(0);
    run_idle(200);
    for (int k = 0; k < 5; k++) chk("rr_order", 32'(grant_log[base + k]), 32'(k % N));

    // requesters 0 and 2 continuously valid
    base = grant_log.size();
    cont[0] = 1; cont[2] = 1; arm(0); arm(2);
    run_grants(6, 0, 600);
    cont[0] = 0; cont[2] = 0;
    run_idle(400);
    for (int k = 0; k < 6; k++) chk("alt_order", 32'(grant_log[base + k]), 32'(exp_alt[k]));

    // slave never answers: timeout error
    lat_mode = 0; arm(3);
    run_idle(200);
    chk("timeout_err", 32'(resp_err), 32'd1);
    chk("timeout_data", resp_data, 32'd0);

    // rx arrives on the timeout cycle itself
    lat_mode = TO; arm(1);
    run_idle(200);
    chk("edge_err", 32'(resp_err), 32'd0);

    // rx arrives after timeout and is ignored
    lat_mode = TO + 4; arm(2);
    run_idle(200);
    chk("late_err", 32'(resp_err), 32'd1);

    // randomized traffic with occasional withdrawn requests
    lat_mode = -1; drop_pct = 3;
    run_grants(40, 1, 5000);
    drop_pct = 0;
    run_idle(1000);

    // reset in the middle of WAIT_RX
    lat_mode = 0; arm(3);
    begin
      int n = 0;
      while (!(hs_done && cyc >= hs_cyc + 3) && n < 100) begin cycle(); n++; end
    end
    chk("pre_reset_busy", 32'(busy), 32'd1);
    do_reset();
    lat_mode = -1;
    for (int i = 0; i < N; i++) arm(i);
    base = grant_log.size();
    run_grants(1, 0, 50);
    chk("post_reset_winner", 32'(grant_log[base]), 32'd0);
    run_idle(800);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
